bp_me_tr_pkt_dispatcher: RTL and testbench

- Fans one trace-replay packet stream out to num_lce_p mock-LCE trace ports, then merges their responses back into one stream in original issue order.
- Lets the single-LCE CCE test harness scale to multi-LCE configurations without changing the trace format.
- Packet format is {opcode, paddr, data}: opcode in the MSBs, data in the LSBs.

---
 rtl/bp_me_tr_pkt_dispatcher_if.sv | 66 ++++++
 rtl/bp_me_tr_pkt_dispatcher.sv | 227 ++++++++++++++++++++++
 tb/tb_bp_me_tr_pkt_dispatcher.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_me_tr_pkt_dispatcher_if.sv
// ---------------------------------------------------------------------------
// bp_me_tr_pkt_dispatcher_if
//
// Bundles every handshake/bus signal of bp_me_tr_pkt_dispatcher.
// Packet layout is {opcode, paddr, data}, with the opcode in the MSBs.
//
//   Ingress   : tr_pkt_v_i / tr_pkt_i / tr_pkt_yumi_o
//   Requests  : lce_tr_pkt_v_o / lce_tr_pkt_o / lce_tr_pkt_yumi_i
//               (channel i occupies bits [i*tr_w +: tr_w])
//   Responses : lce_tr_pkt_v_i / lce_tr_pkt_i / lce_tr_pkt_ready_o
//   Egress    : tr_pkt_v_o / tr_pkt_o / tr_pkt_ready_i
//   Status    : outstanding_o, error_o
//
// Handshakes:
//   - yumi: the consumer raises yumi only in a cycle where the producer's v
//     is high. The transfer happens in that cycle.
//   - ready/valid: a transfer happens in any cycle where v and ready are
//     both high.
//
// Modports:
//   - slave  : the dispatcher's view.
//   - master : the view of the environment that drives it.
// ---------------------------------------------------------------------------
interface bp_me_tr_pkt_dispatcher_if #(
  parameter int num_lce_p        = 2,
  parameter int paddr_width_p    = 40,
  parameter int dword_width_p    = 64,
  parameter int opcode_width_p   = 5,
  parameter int order_fifo_els_p = 8
);
  localparam int tr_w  = opcode_width_p + paddr_width_p + dword_width_p;
  localparam int cnt_w = $clog2(order_fifo_els_p + 1);

  logic                      tr_pkt_v_i;
  logic [tr_w-1:0]           tr_pkt_i;
  logic                      tr_pkt_yumi_o;

  logic [num_lce_p-1:0]      lce_tr_pkt_v_o;
  logic [num_lce_p*tr_w-1:0] lce_tr_pkt_o;
  logic [num_lce_p-1:0]      lce_tr_pkt_yumi_i;

  logic [num_lce_p-1:0]      lce_tr_pkt_v_i;
  logic [num_lce_p*tr_w-1:0] lce_tr_pkt_i;
  logic [num_lce_p-1:0]      lce_tr_pkt_ready_o;

  logic                      tr_pkt_v_o;
  logic [tr_w-1:0]           tr_pkt_o;
  logic                      tr_pkt_ready_i;

  logic [cnt_w-1:0]          outstanding_o;
  logic                      error_o;

  modport slave (
    input  tr_pkt_v_i, tr_pkt_i, lce_tr_pkt_yumi_i, lce_tr_pkt_v_i,
           lce_tr_pkt_i, tr_pkt_ready_i,
    output tr_pkt_yumi_o, lce_tr_pkt_v_o, lce_tr_pkt_o, lce_tr_pkt_ready_o,
           tr_pkt_v_o, tr_pkt_o, outstanding_o, error_o
  );

  modport master (
    output tr_pkt_v_i, tr_pkt_i, lce_tr_pkt_yumi_i, lce_tr_pkt_v_i,
           lce_tr_pkt_i, tr_pkt_ready_i,
    input  tr_pkt_yumi_o, lce_tr_pkt_v_o, lce_tr_pkt_o, lce_tr_pkt_ready_o,
           tr_pkt_v_o, tr_pkt_o, outstanding_o, error_o
  );
endinterface

// File: rtl/bp_me_tr_pkt_dispatcher.sv
// ---------------------------------------------------------------------------
// bp_me_tr_pkt_dispatcher
//
// Fans a single trace-replay packet stream out to num_lce_p mock-LCE trace
// channels. Responses are merged back into one stream in original issue
// order.
//
// Routing selects the target channel in one of two ways:
//   - route_mode_p = 0 : address interleave on paddr[block_offset +: lg_lce].
//   - route_mode_p = 1 : a round-robin pointer.
//
// Ports:
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset
//   io        : bp_me_tr_pkt_dispatcher_if.slave
//               (ingress, per-channel request/response, egress, status)
//
// Datapath:
//   - A one-entry holding register carries the accepted request until the
//     target channel yumis it.
//   - An order FIFO records the target of every accepted packet. Its head
//     selects which per-channel response buffer may drain to egress next.
// ---------------------------------------------------------------------------
module bp_me_tr_pkt_dispatcher #(
  parameter int num_lce_p            = 2,
  parameter int paddr_width_p        = 40,
  parameter int dword_width_p        = 64,
  parameter int opcode_width_p       = 5,
  parameter int block_offset_width_p = 6,
  parameter int route_mode_p         = 0,
  parameter int order_fifo_els_p     = 8
) (
  input logic                      clk_i,
  input logic                      reset_n_i,
  bp_me_tr_pkt_dispatcher_if.slave io
);

  localparam int tr_w   = opcode_width_p + paddr_width_p + dword_width_p;
  localparam int lg_lce = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
  localparam int cnt_w  = $clog2(order_fifo_els_p + 1);
  localparam int ptr_w  = (order_fifo_els_p > 1) ? $clog2(order_fifo_els_p) : 1;

  typedef logic [lg_lce-1:0] lce_id_t;
  typedef logic [tr_w-1:0]   pkt_t;
  typedef logic [ptr_w-1:0]  ptr_t;
  typedef logic [cnt_w-1:0]  cnt_t;

  // Circular pointer increment that wraps at order_fifo_els_p-1, so the
  // depth need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(order_fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Holding register
  logic    hold_v_q,   hold_v_d;
  pkt_t    hold_pkt_q, hold_pkt_d;
  lce_id_t hold_tgt_q, hold_tgt_d;

  // Round-robin pointer
  lce_id_t rr_q, rr_d;

  // Order FIFO
  lce_id_t fifo_mem_q [order_fifo_els_p];
  lce_id_t fifo_mem_d [order_fifo_els_p];
  ptr_t    wr_ptr_q, wr_ptr_d;
  ptr_t    rd_ptr_q, rd_ptr_d;
  cnt_t    count_q,  count_d;

  // Per-channel response buffers and outstanding counters
  logic [num_lce_p-1:0] rsp_v_q, rsp_v_d;
  pkt_t                 rsp_pkt_q [num_lce_p];
  pkt_t                 rsp_pkt_d [num_lce_p];
  cnt_t                 ch_cnt_q  [num_lce_p];
  cnt_t                 ch_cnt_d  [num_lce_p];

  logic error_q, error_d;

  // Combinational intermediates
  lce_id_t              addr_bits;
  lce_id_t              route_tgt;
  logic [num_lce_p-1:0] lce_v;
  logic [num_lce_p-1:0] ch_inc, ch_dec;
  logic                 push, pop, fifo_full, fifo_empty;
  logic                 head_full, egress_v;
  lce_id_t              head;
  pkt_t                 head_pkt;

  assign addr_bits = io.tr_pkt_i[dword_width_p + block_offset_width_p +: lg_lce];

  always_comb begin
    // ---- defaults ----
    hold_v_d   = hold_v_q;
    hold_pkt_d = hold_pkt_q;
    hold_tgt_d = hold_tgt_q;
    rr_d       = rr_q;
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rsp_v_d    = rsp_v_q;
    rsp_pkt_d  = rsp_pkt_q;
    ch_cnt_d   = ch_cnt_q;
    error_d    = error_q;
    lce_v      = '0;
    ch_inc     = '0;
    ch_dec     = '0;
    head_full  = 1'b0;
    head_pkt   = '0;

    // ---- routing ----
    if (num_lce_p == 1) begin
      route_tgt = '0;
    end else if (route_mode_p == 1) begin
      route_tgt = rr_q;
    end else begin
      route_tgt = lce_id_t'(32'(addr_bits) % 32'(num_lce_p));
    end

    // ---- order FIFO status ----
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == cnt_t'(order_fifo_els_p));

    // ---- ingress ----
    // No same-cycle refill: the holding register must be empty to accept.
    push = io.tr_pkt_v_i & ~hold_v_q & ~fifo_full;

    // ---- request issue ----
    for (int i = 0; i < num_lce_p; i++) begin
      if (hold_v_q && (hold_tgt_q == lce_id_t'(i))) lce_v[i] = 1'b1;
    end
    // Masking by lce_v makes a yumi on a non-target channel harmless.
    ch_inc = lce_v & io.lce_tr_pkt_yumi_i;

    // ---- egress head select ----
    head = fifo_mem_q[rd_ptr_q];
    for (int i = 0; i < num_lce_p; i++) begin
      if (head == lce_id_t'(i)) begin
        head_full = rsp_v_q[i];
        head_pkt  = rsp_pkt_q[i];
      end
    end
    egress_v = ~fifo_empty & head_full;
    pop      = egress_v & io.tr_pkt_ready_i;

    // ---- holding register update ----
    if (|ch_inc) hold_v_d = 1'b0;
    if (push) begin
      hold_v_d   = 1'b1;
      hold_pkt_d = io.tr_pkt_i;
      hold_tgt_d = route_tgt;
      if (route_mode_p == 1) begin
        rr_d = (rr_q == lce_id_t'(num_lce_p - 1)) ? '0 : rr_q + 1'b1;
      end
    end

    // ---- order FIFO update ----
    if (push) begin
      fifo_mem_d[wr_ptr_q] = route_tgt;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // ---- response capture / per-channel bookkeeping ----
    // Capture needs an empty buffer and the egress clear needs a full one,
    // so the two never touch the same buffer in one cycle.
    for (int i = 0; i < num_lce_p; i++) begin
      if (io.lce_tr_pkt_v_i[i] && !rsp_v_q[i]) begin
        if (ch_cnt_q[i] == '0) begin
          // Response with nothing outstanding: flag and drop it.
          error_d = 1'b1;
        end else begin
          rsp_v_d[i]   = 1'b1;
          rsp_pkt_d[i] = io.lce_tr_pkt_i[i*tr_w +: tr_w];
          ch_dec[i]    = 1'b1;
        end
      end
      if (pop && (head == lce_id_t'(i))) rsp_v_d[i] = 1'b0;
      if (ch_inc[i] && !ch_dec[i])      ch_cnt_d[i] = ch_cnt_q[i] + 1'b1;
      else if (ch_dec[i] && !ch_inc[i]) ch_cnt_d[i] = ch_cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_v_q   <= 1'b0;
      hold_pkt_q <= '0;
      hold_tgt_q <= '0;
      rr_q       <= '0;
      fifo_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rsp_v_q    <= '0;
      rsp_pkt_q  <= '{default: '0};
      ch_cnt_q   <= '{default: '0};
      error_q    <= 1'b0;
    end else begin
      hold_v_q   <= hold_v_d;
      hold_pkt_q <= hold_pkt_d;
      hold_tgt_q <= hold_tgt_d;
      rr_q       <= rr_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rsp_v_q    <= rsp_v_d;
      rsp_pkt_q  <= rsp_pkt_d;
      ch_cnt_q   <= ch_cnt_d;
      error_q    <= error_d;
    end
  end

  // ---- outputs ----
  // Gating yumi with reset keeps it low while reset is held, even when the
  // holding register is empty and ingress is valid.
  assign io.tr_pkt_yumi_o      = push & reset_n_i;
  assign io.lce_tr_pkt_v_o     = lce_v;
  assign io.lce_tr_pkt_o       = {num_lce_p{hold_pkt_q}};
  assign io.lce_tr_pkt_ready_o = ~rsp_v_q;
  assign io.tr_pkt_v_o         = egress_v;
  assign io.tr_pkt_o           = head_pkt;
  assign io.outstanding_o      = count_q;
  assign io.error_o            = error_q;

endmodule

// File: tb/tb_bp_me_tr_pkt_dispatcher.sv
module tb_bp_me_tr_pkt_dispatcher;
  localparam int NL   = 2;
  localparam int PA   = 40;
  localparam int DW   = 64;
  localparam int OP   = 5;
  localparam int ELS  = 8;
  localparam int TR_W = OP + PA + DW;

  typedef logic [TR_W-1:0] pkt_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  bp_me_tr_pkt_dispatcher_if #(.num_lce_p(NL), .paddr_width_p(PA), .dword_width_p(DW),
    .opcode_width_p(OP), .order_fifo_els_p(ELS)) a0 ();
  bp_me_tr_pkt_dispatcher_if #(.num_lce_p(NL), .paddr_width_p(PA), .dword_width_p(DW),
    .opcode_width_p(OP), .order_fifo_els_p(ELS)) a1 ();

  bp_me_tr_pkt_dispatcher #(.num_lce_p(NL), .paddr_width_p(PA), .dword_width_p(DW),
    .opcode_width_p(OP), .block_offset_width_p(6), .route_mode_p(0),
    .order_fifo_els_p(ELS)) u_dut0 (.clk_i(clk), .reset_n_i(rst_n), .io(a0));

  bp_me_tr_pkt_dispatcher #(.num_lce_p(NL), .paddr_width_p(PA), .dword_width_p(DW),
    .opcode_width_p(OP), .block_offset_width_p(6), .route_mode_p(1),
    .order_fifo_els_p(ELS)) u_dut1 (.clk_i(clk), .reset_n_i(rst_n), .io(a1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic pkt_t mk(input logic [OP-1:0] op, input logic [PA-1:0] pa,
                              input logic [DW-1:0] d);
    return {op, pa, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    a0.tr_pkt_v_i = 0; a0.tr_pkt_i = '0; a0.lce_tr_pkt_yumi_i = '0;
    a0.lce_tr_pkt_v_i = '0; a0.lce_tr_pkt_i = '0; a0.tr_pkt_ready_i = 0;
    a1.tr_pkt_v_i = 0; a1.tr_pkt_i = '0; a1.lce_tr_pkt_yumi_i = '0;
    a1.lce_tr_pkt_v_i = '0; a1.lce_tr_pkt_i = '0; a1.tr_pkt_ready_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  // Present p on ingress until accepted (bounded), then yumi channel ch.
  task automatic issue0(input pkt_t p, input int ch, output bit ok);
    int n;
    ok = 1;
    n  = 0;
    a0.tr_pkt_v_i = 1; a0.tr_pkt_i = p;
    #2;
    while (a0.tr_pkt_yumi_o !== 1'b1 && n < 20) begin
      tick(); #2; n++;
    end
    if (n >= 20) ok = 0;
    tick();
    a0.tr_pkt_v_i = 0;
    a0.lce_tr_pkt_yumi_i = 2'(1 << ch);
    tick();
    a0.lce_tr_pkt_yumi_i = '0;
  endtask

  // One-cycle response pulse on channel ch.
  task automatic resp0(input int ch, input pkt_t p);
    a0.lce_tr_pkt_i = '0;
    a0.lce_tr_pkt_i[ch*TR_W +: TR_W] = p;
    a0.lce_tr_pkt_v_i = 2'(1 << ch);
    tick();
    a0.lce_tr_pkt_v_i = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    a0.tr_pkt_v_i = 1; a0.tr_pkt_i = mk(5'h1, 40'h0, 64'h1);
    #3;
    n_checks++; if (a0.tr_pkt_yumi_o !== 1'b0) $display("FAIL rst_yumi: got %0b expected 0", a0.tr_pkt_yumi_o); else n_pass++;
    n_checks++; if (a0.lce_tr_pkt_v_o !== 2'b00) $display("FAIL rst_lce_v: got %b expected 00", a0.lce_tr_pkt_v_o); else n_pass++;
    n_checks++; if (a0.lce_tr_pkt_ready_o !== 2'b11) $display("FAIL rst_ready: got %b expected 11", a0.lce_tr_pkt_ready_o); else n_pass++;
    n_checks++; if (a0.tr_pkt_v_o !== 1'b0) $display("FAIL rst_v_o: got %0b expected 0", a0.tr_pkt_v_o); else n_pass++;
    n_checks++; if (a0.outstanding_o !== 4'd0) $display("FAIL rst_outstanding: got %0d expected 0", a0.outstanding_o); else n_pass++;
    n_checks++; if (a0.error_o !== 1'b0) $display("FAIL rst_error: got %0b expected 0", a0.error_o); else n_pass++;
    a0.tr_pkt_v_i = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    pkt_t p0, p1, r0, r1;
    p0 = mk(5'h02, 40'h000, 64'h1111); p1 = mk(5'h03, 40'h040, 64'h2222);
    r0 = mk(5'h12, 40'h000, 64'hAAAA); r1 = mk(5'h13, 40'h040, 64'hBBBB);
    a0.tr_pkt_v_i = 1; a0.tr_pkt_i = p0; #2;
    n_checks++; if (a0.tr_pkt_yumi_o !== 1'b1) $display("FAIL basic_yumi0: got %0b expected 1", a0.tr_pkt_yumi_o); else n_pass++;
    tick();
    a0.tr_pkt_i = p1; a0.lce_tr_pkt_yumi_i = 2'b01; #2;
    n_checks++; if (a0.lce_tr_pkt_v_o !== 2'b01) $display("FAIL basic_req_ch0: got %b expected 01", a0.lce_tr_pkt_v_o); else n_pass++;
    n_checks++; if (a0.lce_tr_pkt_o[0 +: TR_W] !== p0) $display("FAIL basic_req_pkt0: got %h expected %h", a0.lce_tr_pkt_o[0 +: TR_W], p0); else n_pass++;
    n_checks++; if (a0.tr_pkt_yumi_o !== 1'b0) $display("FAIL basic_no_refill: got %0b expected 0", a0.tr_pkt_yumi_o); else n_pass++;
    n_checks++; if (a0.outstanding_o !== 4'd1) $display("FAIL basic_out1: got %0d expected 1", a0.outstanding_o); else n_pass++;
    tick();
    a0.lce_tr_pkt_yumi_i = '0; #2;
    n_checks++; if (a0.tr_pkt_yumi_o !== 1'b1) $display("FAIL basic_yumi1: got %0b expected 1", a0.tr_pkt_yumi_o); else n_pass++;
    tick();
    a0.tr_pkt_v_i = 0; a0.lce_tr_pkt_yumi_i = 2'b10;
    a0.lce_tr_pkt_i = '0; a0.lce_tr_pkt_i[0 +: TR_W] = r0; a0.lce_tr_pkt_v_i = 2'b01; #2;
    n_checks++; if (a0.lce_tr_pkt_v_o !== 2'b10) $display("FAIL basic_req_ch1: got %b expected 10", a0.lce_tr_pkt_v_o); else n_pass++;
    n_checks++; if (a0.lce_tr_pkt_o[TR_W +: TR_W] !== p1) $display("FAIL basic_req_pkt1: got %h expected %h", a0.lce_tr_pkt_o[TR_W +: TR_W], p1); else n_pass++;
    n_checks++; if (a0.outstanding_o !== 4'd2) $display("FAIL basic_out2: got %0d expected 2", a0.outstanding_o); else n_pass++;
    tick();
    a0.lce_tr_pkt_yumi_i = '0; a0.lce_tr_pkt_i = '0; a0.lce_tr_pkt_i[TR_W +: TR_W] = r1;
    a0.lce_tr_pkt_v_i = 2'b10; a0.tr_pkt_ready_i = 1; #2;
    n_checks++; if (a0.tr_pkt_v_o !== 1'b1 || a0.tr_pkt_o !== r0) $display("FAIL basic_egress0: got v=%0b pkt=%h expected v=1 pkt=%h", a0.tr_pkt_v_o, a0.tr_pkt_o, r0); else n_pass++;
    n_checks++; if (a0.lce_tr_pkt_ready_o !== 2'b10) $display("FAIL basic_ready: got %b expected 10", a0.lce_tr_pkt_ready_o); else n_pass++;
    tick();
    a0.lce_tr_pkt_v_i = '0; #2;
    n_checks++; if (a0.tr_pkt_v_o !== 1'b1 || a0.tr_pkt_o !== r1) $display("FAIL basic_egress1: got v=%0b pkt=%h expected v=1 pkt=%h", a0.tr_pkt_v_o, a0.tr_pkt_o, r1); else n_pass++;
    n_checks++; if (a0.outstanding_o !== 4'd1) $display("FAIL basic_out3: got %0d expected 1", a0.outstanding_o); else n_pass++;
    tick(); #2;
    n_checks++; if (a0.tr_pkt_v_o !== 1'b0 || a0.outstanding_o !== 4'd0) $display("FAIL basic_drained: got v=%0b out=%0d expected v=0 out=0", a0.tr_pkt_v_o, a0.outstanding_o); else n_pass++;
    a0.tr_pkt_ready_i = 0;
    tick();
  endtask

  task automatic test_out_of_order();
    pkt_t r0, r1;
    bit ok0, ok1, bad;
    r0 = mk(5'h04, 40'h080, 64'hC0C0); r1 = mk(5'h05, 40'h0C0, 64'hC1C1);
    issue0(mk(5'h01, 40'h080, 64'h10), 0, ok0);
    issue0(mk(5'h01, 40'h0C0, 64'h11), 1, ok1);
    n_checks++; if ((ok0 & ok1) !== 1'b1) $display("FAIL ooo_issue: got %0b expected 1", ok0 & ok1); else n_pass++;
    a0.tr_pkt_ready_i = 1;
    resp0(1, r1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      #2;
      if (a0.tr_pkt_v_o !== 1'b0 || a0.lce_tr_pkt_ready_o[1] !== 1'b0) bad = 1;
      tick();
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL ooo_hold: got bad=%0b expected 0 (v_o=%0b ready=%b)", bad, a0.tr_pkt_v_o, a0.lce_tr_pkt_ready_o); else n_pass++;
    n_checks++; if (a0.outstanding_o !== 4'd2) $display("FAIL ooo_out2: got %0d expected 2", a0.outstanding_o); else n_pass++;
    resp0(0, r0);
    #2;
    n_checks++; if (a0.tr_pkt_v_o !== 1'b1 || a0.tr_pkt_o !== r0) $display("FAIL ooo_egress0: got v=%0b pkt=%h expected v=1 pkt=%h", a0.tr_pkt_v_o, a0.tr_pkt_o, r0); else n_pass++;
    tick(); #2;
    n_checks++; if (a0.tr_pkt_v_o !== 1'b1 || a0.tr_pkt_o !== r1) $display("FAIL ooo_egress1: got v=%0b pkt=%h expected v=1 pkt=%h", a0.tr_pkt_v_o, a0.tr_pkt_o, r1); else n_pass++;
    tick(); #2;
    n_checks++; if (a0.tr_pkt_v_o !== 1'b0 || a0.outstanding_o !== 4'd0) $display("FAIL ooo_drained: got v=%0b out=%0d expected v=0 out=0", a0.tr_pkt_v_o, a0.outstanding_o); else n_pass++;
    a0.tr_pkt_ready_i = 0;
    tick();
  endtask

  task automatic test_full_fifo();
    bit ok, all_ok, bad;
    pkt_t rf0;
    rf0 = mk(5'h1F, 40'h0, 64'hF00D);
    all_ok = 1;
    a0.tr_pkt_ready_i = 0;
    for (int k = 0; k < 8; k++) begin
      issue0(mk(5'h01, 40'(k * 64), 64'(k)), k % 2, ok);
      all_ok &= ok;
    end
    n_checks++; if (all_ok !== 1'b1) $display("FAIL full_issue8: got %0b expected 1", all_ok); else n_pass++;
    n_checks++; if (a0.outstanding_o !== 4'd8) $display("FAIL full_out8: got %0d expected 8", a0.outstanding_o); else n_pass++;
    a0.tr_pkt_v_i = 1; a0.tr_pkt_i = mk(5'h09, 40'h0, 64'h9);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      #2; if (a0.tr_pkt_yumi_o !== 1'b0) bad = 1;
      tick();
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL full_yumi_blocked: got bad=%0b expected 0", bad); else n_pass++;
    resp0(0, rf0);
    a0.tr_pkt_ready_i = 1; #2;
    n_checks++; if (a0.tr_pkt_v_o !== 1'b1 || a0.tr_pkt_o !== rf0) $display("FAIL full_egress: got v=%0b pkt=%h expected v=1 pkt=%h", a0.tr_pkt_v_o, a0.tr_pkt_o, rf0); else n_pass++;
    n_checks++; if (a0.tr_pkt_yumi_o !== 1'b0) $display("FAIL full_yumi_at_pop: got %0b expected 0", a0.tr_pkt_yumi_o); else n_pass++;
    tick();
    a0.tr_pkt_ready_i = 0; #2;
    n_checks++; if (a0.tr_pkt_yumi_o !== 1'b1) $display("FAIL full_yumi_after_pop: got %0b expected 1", a0.tr_pkt_yumi_o); else n_pass++;
    n_checks++; if (a0.outstanding_o !== 4'd7) $display("FAIL full_out7: got %0d expected 7", a0.outstanding_o); else n_pass++;
    tick();
    a0.tr_pkt_v_i = 0; #2;
    n_checks++; if (a0.outstanding_o !== 4'd8) $display("FAIL full_out8b: got %0d expected 8", a0.outstanding_o); else n_pass++;
    do_reset();
  endtask

  task automatic test_mode1();
    logic [1:0] exp_mask [5];
    bit acc_bad;
    exp_mask = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    acc_bad = 0;
    for (int k = 0; k < 5; k++) begin
      a1.tr_pkt_v_i = 1; a1.tr_pkt_i = mk(5'h02, 40'h0, 64'(k)); #2;
      if (a1.tr_pkt_yumi_o !== 1'b1) acc_bad = 1;
      tick();
      a1.tr_pkt_v_i = 0; a1.lce_tr_pkt_yumi_i = exp_mask[k]; #2;
      n_checks++; if (a1.lce_tr_pkt_v_o !== exp_mask[k]) $display("FAIL rr_target%0d: got %b expected %b", k, a1.lce_tr_pkt_v_o, exp_mask[k]); else n_pass++;
      tick();
      a1.lce_tr_pkt_yumi_i = '0;
    end
    n_checks++; if (acc_bad !== 1'b0) $display("FAIL rr_accept: got bad=%0b expected 0", acc_bad); else n_pass++;
    n_checks++; if (a1.outstanding_o !== 4'd5) $display("FAIL rr_out5: got %0d expected 5", a1.outstanding_o); else n_pass++;
  endtask

  task automatic test_spurious();
    bit bad;
    a0.tr_pkt_ready_i = 1;
    a0.lce_tr_pkt_i = '0; a0.lce_tr_pkt_i[TR_W +: TR_W] = mk(5'h1E, 40'h40, 64'hDEAD);
    a0.lce_tr_pkt_v_i = 2'b10; #2;
    n_checks++; if (a0.error_o !== 1'b0) $display("FAIL spur_error_before: got %0b expected 0", a0.error_o); else n_pass++;
    tick();
    a0.lce_tr_pkt_v_i = '0; #2;
    n_checks++; if (a0.error_o !== 1'b1) $display("FAIL spur_error_next: got %0b expected 1", a0.error_o); else n_pass++;
    n_checks++; if (a0.lce_tr_pkt_ready_o !== 2'b11) $display("FAIL spur_dropped: got %b expected 11", a0.lce_tr_pkt_ready_o); else n_pass++;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); #2;
      if (a0.error_o !== 1'b1 || a0.tr_pkt_v_o !== 1'b0) bad = 1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL spur_sticky: got bad=%0b expected 0 (err=%0b v_o=%0b)", bad, a0.error_o, a0.tr_pkt_v_o); else n_pass++;
    a0.tr_pkt_ready_i = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok, all_ok;
    pkt_t r0;
    r0 = mk(5'h07, 40'h100, 64'h7777);
    all_ok = 1;
    issue0(mk(5'h01, 40'h000, 64'h1), 0, ok); all_ok &= ok;
    issue0(mk(5'h01, 40'h040, 64'h2), 1, ok); all_ok &= ok;
    issue0(mk(5'h01, 40'h080, 64'h3), 0, ok); all_ok &= ok;
    resp0(0, mk(5'h08, 40'h0, 64'h8));
    a0.tr_pkt_v_i = 1; a0.tr_pkt_i = mk(5'h01, 40'h0C0, 64'h4); #2;
    n_checks++; if (all_ok !== 1'b1 || a0.outstanding_o !== 4'd3 || a0.tr_pkt_v_o !== 1'b1) $display("FAIL mid_pre: got ok=%0b out=%0d v_o=%0b expected ok=1 out=3 v_o=1", all_ok, a0.outstanding_o, a0.tr_pkt_v_o); else n_pass++;
    rst_n = 0; #1;
    n_checks++; if (a0.outstanding_o !== 4'd0) $display("FAIL mid_out: got %0d expected 0", a0.outstanding_o); else n_pass++;
    n_checks++; if (a0.error_o !== 1'b0) $display("FAIL mid_error: got %0b expected 0", a0.error_o); else n_pass++;
    n_checks++; if (a0.tr_pkt_v_o !== 1'b0 || a0.tr_pkt_yumi_o !== 1'b0 || a0.lce_tr_pkt_v_o !== 2'b00) $display("FAIL mid_valids: got v_o=%0b yumi=%0b lce_v=%b expected 0 0 00", a0.tr_pkt_v_o, a0.tr_pkt_yumi_o, a0.lce_tr_pkt_v_o); else n_pass++;
    n_checks++; if (a0.lce_tr_pkt_ready_o !== 2'b11) $display("FAIL mid_ready: got %b expected 11", a0.lce_tr_pkt_ready_o); else n_pass++;
    idle_inputs();
    tick(); tick();
    rst_n = 1;
    tick();
    issue0(mk(5'h01, 40'h100, 64'h5), 0, ok);
    resp0(0, r0);
    a0.tr_pkt_ready_i = 1; #2;
    n_checks++; if (ok !== 1'b1 || a0.tr_pkt_v_o !== 1'b1 || a0.tr_pkt_o !== r0 || a0.outstanding_o !== 4'd1) $display("FAIL post_rst_egress: got ok=%0b v=%0b pkt=%h out=%0d expected ok=1 v=1 pkt=%h out=1", ok, a0.tr_pkt_v_o, a0.tr_pkt_o, a0.outstanding_o, r0); else n_pass++;
    tick(); #2;
    n_checks++; if (a0.outstanding_o !== 4'd0 || a0.tr_pkt_v_o !== 1'b0 || a0.error_o !== 1'b0) $display("FAIL post_rst_drained: got out=%0d v=%0b err=%0b expected 0 0 0", a0.outstanding_o, a0.tr_pkt_v_o, a0.error_o); else n_pass++;
    a0.tr_pkt_ready_i = 0;
    tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_out_of_order();
    test_full_fifo();
    test_mode1();
    do_reset();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
